ins_fetch_unit: RTL and testbench
=================================

Name: ins_fetch_unit

Overview:
Fetch stage sitting directly upstream of the instruction memory and downstream-feeding the decoder.
- Owns the PC and drives the byte address into the big-endian, combinational-read instruction memory.
- Latches the returned word into an instruction register (IR) and presents it to decode with a valid/ready handshake.
- Computes branch, jump and register redirect targets, and stops fetching on the halt opcode.

Parameters:
RESET_PC, 32'h0000_0100, PC value loaded on reset (first instruction address).
HALT_OP, 6'b111111, opcode (ir[31:26]) that stops fetching.

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
IAddr  out  32  byte address to instruction memory; equals current PC
IDataOut  in  32  instruction word from memory, valid in the same cycle as IAddr
ir  out  32  latched instruction for decode
ir_pc4  out  32  address of instruction in ir, plus 4
ir_valid  out  1  ir holds an unconsumed instruction
ir_ready  in  1  decode consumes ir this cycle
redirect  in  1  control flow change for the instruction in ir; only honoured with ir_valid=1, and implies consume
PCSrc  in  2  redirect kind: 01 branch, 10 jump, 11 register; 00 with redirect=1 is ignored (treated as a plain consume)
jr_addr  in  32  register target for PCSrc=11
halted  out  1  fetch stopped by HALT_OP

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, named Reset.
- Reset values: on Reset=1 at the clock edge:
  - PC=RESET_PC, ir=0, ir_pc4=0, ir_valid=0, halted=0, state=FETCH.
  - Reset wins over every other input, in every state.
- IAddr is combinational from the PC register. IDataOut is sampled at the clock edge.
- FSM states: FETCH, FULL, HALT.
- FETCH (IR empty):
  - Each edge: ir<=IDataOut, ir_pc4<=PC+4, ir_valid<=1, go to FULL.
  - PC<=PC+4 unless IDataOut[31:26]==HALT_OP, in which case PC holds.
- FULL, ir_ready=0: hold ir, ir_pc4, ir_valid and PC (backpressure).
- FULL, ir_ready=1, redirect=0:
  - If the ir opcode is HALT_OP: ir_valid<=0, halted<=1, go to HALT.
  - Otherwise load the next word back-to-back: ir<=IDataOut, ir_pc4<=PC+4, PC updated as in FETCH, stay FULL.
  - Throughput is 1 instruction per cycle.
- FULL, redirect=1 (ir_ready is don't-care): PC<=target, ir_valid<=0, go to FETCH.
  - The prefetched word at the old PC is discarded.
  - Redirect penalty is 1 bubble cycle.
- Target arithmetic:
  - Branch: ir_pc4 + (sign-extend(ir[15:0]) << 2), modulo 2^32.
  - Jump: {ir_pc4[31:28], ir[25:0], 2'b00}.
  - Register: {jr_addr[31:2], 2'b00}; the low bits are forced to 0.
- Precedence:
  - Redirect on a halt instruction takes the redirect (no halt).
  - Redirect with ir_valid=0 is ignored.
- HALT: IAddr frozen at the halt address, ir_valid=0, halted=1. The block leaves HALT only through Reset.
- PC wrap: 32'hFFFF_FFFC+4 wraps to 0 silently.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSrc encodings PC_NEXT, PC_BR, PC_J, PC_JR.
  - The HALT_OP constant.
  - Field slice constants for opcode, imm16 and addr26.
  - The fetch state enum.
- One combinational sub-module, next_pc_calc:
  - Inputs: ir, ir_pc4, jr_addr, PCSrc.
  - Output: 32-bit target.
- ins_fetch_unit holds the PC, IR and FSM.

Test Plan:
- Reset with memory[0x100]=0x48010002 -> IAddr=0x100 during reset. After the first edge post-reset: ir=0x48010002, ir_pc4=0x104, ir_valid=1, IAddr=0x104.
- ir_ready held 1 over 0x100..0x10C -> ir takes 0x48010002, 0x08020003, 0x04411800, 0x40222000 on consecutive edges with no bubbles. Then ir_ready=0 for 3 cycles -> ir and IAddr frozen.
- ir=0xD023FFFE, ir_pc4=0x130, redirect=1, PCSrc=01 -> next IAddr=0x128, ir_valid=0 for one cycle, then ir=memory word at 0x128.
- ir=0xE000004D, ir_pc4=0x0FC, PCSrc=10 -> IAddr=0x134. With PCSrc=11 and jr_addr=0x13B -> IAddr=0x138.
- HALT 0xFC000000 at 0x130 consumed -> halted=1, ir_valid=0, IAddr stays 0x130 for 10+ cycles. Reset asserted -> IAddr=0x100, halted=0.
- Reset asserted in FULL with redirect=1 on the same edge -> PC=0x100, ir_valid=0, and the redirect target is not applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: redirect encodings, halt opcode, field slices, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Redirect kind driven by decode on PCSrc
    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_J    = 2'b10;
    localparam logic [1:0] PC_JR   = 2'b11;

    // Opcode that stops fetching
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // Instruction field positions
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 25;
    localparam int ADDR_LO = 0;

    // Fetch FSM: FETCH = IR empty, FULL = IR holds a word for decode, HALT = stopped until reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target generator for the instruction held in ir (branch, jump, register).
// Latency: purely combinational.
// Backpressure: none; the result is only used when fetch accepts a redirect.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [31:0] ir_pc4,
    input  logic [31:0] jr_addr,
    input  logic [1:0]  PCSrc,
    output logic [31:0] target
);

    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        unused_ir_bits;

    // Opcode bits select nothing here; they are consumed by the fetch FSM
    assign unused_ir_bits = &{1'b0, ir[OP_HI:OP_LO]};

    // Candidate targets; the branch offset is a word count, so it is scaled by 4
    always_comb begin
        br_target = ir_pc4 + {{14{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO], 2'b00};
        j_target  = {ir_pc4[31:28], ir[ADDR_HI:ADDR_LO], 2'b00};
        jr_target = jr_addr & 32'hFFFF_FFFC;
    end

    // Select by redirect kind; PC_NEXT falls back to sequential flow
    always_comb begin
        target = ir_pc4;
        case (PCSrc)
            PC_BR:   target = br_target;
            PC_J:    target = j_target;
            PC_JR:   target = jr_target;
            default: target = ir_pc4;
        endcase
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory, holds the IR for decode.
// Latency: IR loads on the edge after IAddr is presented; 1 instr/cycle, 1 bubble per redirect.
// Backpressure: ir_ready=0 in FULL freezes PC and IR; halt freezes fetch until Reset.
module ins_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0100,
    parameter logic [5:0]  HALT_OP  = HALT_OPCODE
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] IAddr,
    input  logic [31:0] IDataOut,
    output logic [31:0] ir,
    output logic [31:0] ir_pc4,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] jr_addr,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic [31:0]  pc_after_fetch;
    logic [31:0]  target;
    logic         fetch_is_halt;
    logic         ir_is_halt;
    logic         take_redirect;
    logic         consume;

    assign IAddr = pc;

    next_pc_calc u_next_pc_calc (
        .ir      (ir),
        .ir_pc4  (ir_pc4),
        .jr_addr (jr_addr),
        .PCSrc   (PCSrc),
        .target  (target)
    );

    // Sequential-fetch address and control decode; a fetched halt word parks the PC on itself
    always_comb begin
        pc_inc         = pc + 32'd4;
        fetch_is_halt  = (IDataOut[OP_HI:OP_LO] == HALT_OP);
        pc_after_fetch = fetch_is_halt ? pc : pc_inc;
        ir_is_halt     = (ir[OP_HI:OP_LO] == HALT_OP);
        take_redirect  = redirect && (PCSrc != PC_NEXT);
        consume        = ir_ready || redirect;
    end

    // PC, IR and fetch FSM; a redirect outranks a pending halt in ir
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 32'd0;
            ir_pc4   <= 32'd0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir       <= IDataOut;
                    ir_pc4   <= pc_inc;
                    ir_valid <= 1'b1;
                    pc       <= pc_after_fetch;
                    state    <= S_FULL;
                end
                S_FULL: begin
                    if (take_redirect) begin
                        pc       <= target;
                        ir_valid <= 1'b0;
                        state    <= S_FETCH;
                    end else if (consume) begin
                        if (ir_is_halt) begin
                            ir_valid <= 1'b0;
                            halted   <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            ir     <= IDataOut;
                            ir_pc4 <= pc_inc;
                            pc     <= pc_after_fetch;
                        end
                    end
                end
                S_HALT: begin
                    ir_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    ir_valid <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: program memory model, consumed-instruction scoreboard.
// Latency: n/a.
// Backpressure: bench drives ir_ready/redirect directly.
module tb_ins_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] IAddr;
    logic [31:0] IDataOut;
    logic [31:0] ir;
    logic [31:0] ir_pc4;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [1:0]  PCSrc;
    logic [31:0] jr_addr;
    logic        halted;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem [0:255];
    logic [63:0] sb_q [$];

    ins_fetch_unit dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .IAddr    (IAddr),
        .IDataOut (IDataOut),
        .ir       (ir),
        .ir_pc4   (ir_pc4),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .redirect (redirect),
        .PCSrc    (PCSrc),
        .jr_addr  (jr_addr),
        .halted   (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational big-endian word memory, 256 words aliased over the address space
    always_comb IDataOut = mem[IAddr[9:2]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        return mem[addr[9:2]];
    endfunction

    // Expected contents of ir/ir_pc4 for the instruction fetched from addr
    task automatic push_exp(input logic [31:0] addr);
        sb_q.push_back({mem_rd(addr), addr + 32'd4});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every instruction decode takes (ready or redirect while valid) must match in order
    always @(negedge CLK) begin
        if (!Reset && ir_valid && (ir_ready || redirect)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_depth", sb_q.size(), 1);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check_eq("sb_ir", ir, e[63:32]);
                check_eq("sb_ir_pc4", ir_pc4, e[31:0]);
            end
        end
    end

    task automatic jr_to(input logic [31:0] a);
        redirect = 1'b1;
        PCSrc    = 2'b11;
        jr_addr  = a;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h3E] = 32'hE000_004D;  // 0x0F8
        mem[8'h40] = 32'h4801_0002;  // 0x100
        mem[8'h41] = 32'h0802_0003;  // 0x104
        mem[8'h42] = 32'h0441_1800;  // 0x108
        mem[8'h43] = 32'h4022_2000;  // 0x10C
        mem[8'h44] = 32'h0C00_0001;  // 0x110
        mem[8'h4A] = 32'h2001_0128;  // 0x128
        mem[8'h4B] = 32'hD023_FFFE;  // 0x12C
        mem[8'h4C] = 32'hFC00_0000;  // 0x130 halt
        mem[8'h4D] = 32'h2400_0134;  // 0x134
        mem[8'h4E] = 32'h2800_0138;  // 0x138
        mem[8'h4F] = 32'h2C00_013C;  // 0x13C
        mem[8'hFF] = 32'h1122_3344;  // 0xFFFFFFFC

        Reset = 1'b1; ir_ready = 1'b0; redirect = 1'b0; PCSrc = 2'b00; jr_addr = 32'd0;
        tick(); tick();
        check_eq("rst_iaddr", IAddr, 32'h100);
        check_eq("rst_ir", ir, 32'h0);
        check_eq("rst_ir_pc4", ir_pc4, 32'h0);
        check_eq("rst_valid", {31'd0, ir_valid}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);

        // First fetch
        Reset = 1'b0;
        tick();
        check_eq("f1_ir", ir, 32'h4801_0002);
        check_eq("f1_ir_pc4", ir_pc4, 32'h104);
        check_eq("f1_valid", {31'd0, ir_valid}, 32'd1);
        check_eq("f1_iaddr", IAddr, 32'h104);

        // Back-to-back consumption, no bubbles
        for (int k = 0; k < 4; k++) push_exp(32'h100 + 32'(4 * k));
        ir_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("b2b_valid", {31'd0, ir_valid}, 32'd1);
            check_eq("b2b_iaddr", IAddr, 32'h108 + 32'(4 * k));
        end
        ir_ready = 1'b0;

        // Backpressure freezes ir and IAddr
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("bp_ir", ir, 32'h0C00_0001);
            check_eq("bp_iaddr", IAddr, 32'h114);
        end

        // Register redirect to 0x12C
        push_exp(32'h110);
        jr_to(32'h12F);
        check_eq("jr_valid", {31'd0, ir_valid}, 32'd0);
        check_eq("jr_iaddr", IAddr, 32'h12C);
        tick();
        check_eq("br_pre_ir", ir, 32'hD023_FFFE);
        check_eq("br_pre_pc4", ir_pc4, 32'h130);

        // Backward branch: 0x130 - 8 = 0x128
        push_exp(32'h12C);
        redirect = 1'b1; PCSrc = 2'b01;
        tick();
        redirect = 1'b0;
        check_eq("br_iaddr", IAddr, 32'h128);
        check_eq("br_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        check_eq("br_ir", ir, 32'h2001_0128);
        check_eq("br_valid2", {31'd0, ir_valid}, 32'd1);

        // Jump from 0x0F8
        push_exp(32'h128);
        jr_to(32'h0FA);
        tick();
        check_eq("j_pre_ir", ir, 32'hE000_004D);
        check_eq("j_pre_pc4", ir_pc4, 32'h0FC);
        push_exp(32'h0F8);
        redirect = 1'b1; PCSrc = 2'b10;
        tick();
        check_eq("j_iaddr", IAddr, 32'h134);
        check_eq("j_valid", {31'd0, ir_valid}, 32'd0);

        // Redirect held during the bubble must be ignored
        PCSrc = 2'b11; jr_addr = 32'h200;
        tick();
        check_eq("ign_iaddr", IAddr, 32'h138);
        check_eq("ign_ir", ir, 32'h2400_0134);

        // Register redirect with low bits dropped
        push_exp(32'h134);
        jr_to(32'h13B);
        check_eq("jr2_iaddr", IAddr, 32'h138);
        tick();

        // PCSrc=00 with redirect acts as a plain consume
        push_exp(32'h138);
        redirect = 1'b1; PCSrc = 2'b00;
        tick();
        redirect = 1'b0;
        check_eq("nop_rd_valid", {31'd0, ir_valid}, 32'd1);
        check_eq("nop_rd_ir", ir, 32'h2C00_013C);
        check_eq("nop_rd_iaddr", IAddr, 32'h140);

        // Halt word in ir, but a redirect wins
        push_exp(32'h13C);
        jr_to(32'h130);
        tick();
        check_eq("hw_iaddr", IAddr, 32'h130);
        check_eq("hw_ir", ir, 32'hFC00_0000);
        push_exp(32'h130);
        jr_to(32'h100);
        check_eq("hw_rd_halted", {31'd0, halted}, 32'd0);
        check_eq("hw_rd_iaddr", IAddr, 32'h100);
        tick();

        // Halt consumed
        push_exp(32'h100);
        jr_to(32'h130);
        tick();
        push_exp(32'h130);
        ir_ready = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            check_eq("halt_halted", {31'd0, halted}, 32'd1);
            check_eq("halt_valid", {31'd0, ir_valid}, 32'd0);
            check_eq("halt_iaddr", IAddr, 32'h130);
            redirect = k[0]; PCSrc = 2'b11; jr_addr = 32'h200;
            tick();
        end
        redirect = 1'b0; ir_ready = 1'b0;
        Reset = 1'b1;
        tick();
        check_eq("hrst_iaddr", IAddr, 32'h100);
        check_eq("hrst_halted", {31'd0, halted}, 32'd0);
        Reset = 1'b0;
        tick();

        // Reset beats a same-edge redirect in FULL
        Reset = 1'b1; redirect = 1'b1; PCSrc = 2'b11; jr_addr = 32'h200;
        tick();
        check_eq("rr_iaddr", IAddr, 32'h100);
        check_eq("rr_valid", {31'd0, ir_valid}, 32'd0);
        check_eq("rr_ir", ir, 32'h0);
        Reset = 1'b0; redirect = 1'b0;
        tick();

        // PC wraps from 0xFFFFFFFC to 0
        push_exp(32'h100);
        jr_to(32'hFFFF_FFFF);
        check_eq("wrap_iaddr0", IAddr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_ir", ir, 32'h1122_3344);
        check_eq("wrap_pc4", ir_pc4, 32'h0);
        check_eq("wrap_iaddr", IAddr, 32'h0);

        check_eq("sb_left", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
